// File: rtl/pe_seq_if.sv
// rtl/pe_seq_if.sv - control/handshake bundle between conv controller, pe_seq_ctrl and PE array buffers
interface pe_seq_if #(parameter int CFG_W = 2);
  logic             start_conv;
  logic             start_tile;
  logic             stall;
  logic [CFG_W-1:0] cfg_ci;
  logic [CFG_W-1:0] cfg_co;
  logic             ifm_read;
  logic             wgt_read;
  logic             p_valid_out;
  logic             last_ch_out;
  logic             busy;
  logic             tile_done;
  logic             end_conv;

  modport master (
    output start_conv, start_tile, stall, cfg_ci, cfg_co,
    input  ifm_read, wgt_read, p_valid_out, last_ch_out, busy, tile_done, end_conv
  );

  modport slave (
    input  start_conv, start_tile, stall, cfg_ci, cfg_co,
    output ifm_read, wgt_read, p_valid_out, last_ch_out, busy, tile_done, end_conv
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - PE array sequencer: per-channel weight load + stream, tile and conversion tracking
module pe_seq_ctrl #(
  parameter int KSIZE      = 5,
  parameter int TILE_LEN   = 16,
  parameter int TILES      = 15,
  parameter int CFG_W      = 2,
  parameter int PIPE_DEPTH = 4
) (
  input logic    clk,
  input logic    rst,
  pe_seq_if.slave bus
);
  localparam int CNT_MAX = (KSIZE > TILE_LEN) ? KSIZE : TILE_LEN;
  localparam int KW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int NW      = CFG_W + 4;
  localparam int TW_RAW  = $clog2((2 ** CFG_W) * 8 * TILES);
  localparam int TW      = (TW_RAW < 1) ? 1 : TW_RAW;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t                state;
  logic [KW-1:0]         kcnt;
  logic [NW-1:0]         ci_n;
  logic [NW-1:0]         co_n;
  logic [NW-1:0]         ch;
  logic [TW-1:0]         tile;
  logic                  armed;
  logic                  tile_done_q;
  logic                  end_conv_q;
  logic [PIPE_DEPTH-1:0] pv_sr;
  logic [PIPE_DEPTH-1:0] lc_sr;

  logic run;
  logic p_valid_int;
  logic last_ch_int;
  logic is_last_ch;
  logic is_last_tile;

  // Pops are decoded straight from state and stall so a stalled cycle never pops.
  assign run          = ((state == LOAD) || (state == STREAM)) && !bus.stall;
  assign is_last_ch   = (ch == ci_n - NW'(1));
  assign is_last_tile = (32'(tile) == 32'(co_n) * TILES - 32'd1);
  assign p_valid_int  = run && (state == STREAM);
  assign last_ch_int  = p_valid_int && is_last_ch;

  assign bus.ifm_read    = run;
  assign bus.wgt_read    = run && (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign bus.p_valid_out = pv_sr[PIPE_DEPTH-1];
  assign bus.last_ch_out = lc_sr[PIPE_DEPTH-1];
  assign bus.tile_done   = tile_done_q;
  assign bus.end_conv    = end_conv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kcnt        <= '0;
      ci_n        <= '0;
      co_n        <= '0;
      ch          <= '0;
      tile        <= '0;
      armed       <= 1'b0;
      tile_done_q <= 1'b0;
      end_conv_q  <= 1'b0;
      pv_sr       <= '0;
      lc_sr       <= '0;
    end else begin
      tile_done_q <= 1'b0;
      end_conv_q  <= 1'b0;
      // The MAC-latency pipe keeps shifting through stalls, so stalls surface as bubbles.
      pv_sr[0] <= p_valid_int;
      lc_sr[0] <= last_ch_int;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pv_sr[i] <= pv_sr[i-1];
        lc_sr[i] <= lc_sr[i-1];
      end
      case (state)
        IDLE: begin
          if (bus.start_conv) begin
            ci_n  <= (NW'(bus.cfg_ci) + NW'(1)) << 3;
            co_n  <= (NW'(bus.cfg_co) + NW'(1)) << 3;
            tile  <= '0;
            armed <= 1'b1;
          end else if (bus.start_tile && armed) begin
            state <= LOAD;
            ch    <= '0;
            kcnt  <= '0;
          end
        end
        LOAD: begin
          if (!bus.stall) begin
            if (kcnt == KW'(KSIZE - 1)) begin
              kcnt  <= '0;
              state <= STREAM;
            end else begin
              kcnt <= kcnt + KW'(1);
            end
          end
        end
        STREAM: begin
          if (!bus.stall) begin
            if (kcnt == KW'(TILE_LEN - 1)) begin
              kcnt <= '0;
              if (!is_last_ch) begin
                ch    <= ch + NW'(1);
                state <= LOAD;
              end else begin
                tile        <= tile + TW'(1);
                tile_done_q <= 1'b1;
                if (is_last_tile) begin
                  end_conv_q <= 1'b1;
                  state      <= FINISH;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              kcnt <= kcnt + KW'(1);
            end
          end
        end
        FINISH: begin
          armed <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
